// File: rtl/axil_reg_slave_if.sv
// -----------------------------------------------------------------------------
// axil_reg_slave_if
// AXI4-Lite bus bundle between a host master and the axil_reg_slave register
// file. Carries the five AXI4-Lite channels (AW, W, B, AR, R).
//
// Parameters
//   ADDR_WIDTH : byte-address width of awaddr/araddr
//   DATA_WIDTH : data width (32 or 64); wstrb is DATA_WIDTH/8 bits
//
// Modports
//   master : drives addresses, write data, valids on AW/W/AR and ready on B/R
//   slave  : drives ready on AW/W/AR and the B/R response channels
// -----------------------------------------------------------------------------
interface axil_reg_slave_if #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32
);
    // AW channel
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [2:0]              awprot;
    // W channel
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    // B channel
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    // AR channel
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [2:0]              arprot;
    // R channel
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, awprot, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, arprot, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awvalid, awprot, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, arprot, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axil_reg_slave.sv
// -----------------------------------------------------------------------------
// axil_reg_slave
// AXI4-Lite slave register file exposing NUM_REGS DATA_WIDTH-bit registers.
// Byte strobes, per-register read-only masking (SLVERR on write), SLVERR on
// out-of-range addresses, and a hardware-side full-word load port per register.
//
// Ports
//   clk          : clock
//   reset        : synchronous active-high reset
//   s_axil       : AXI4-Lite slave bus (axil_reg_slave_if.slave)
//   reg_q        : current register contents, reg i = slice i
//   reg_wr_pulse : 1-cycle pulse per register when an AXI write commits to it
//   hw_we        : per-register hardware load enable
//   hw_wdata     : hardware load data, reg i = slice i
// -----------------------------------------------------------------------------
module axil_reg_slave #(
    parameter int                             ADDR_WIDTH = 13,
    parameter int                             DATA_WIDTH = 32,
    parameter int                             NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0]            RO_MASK    = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    axil_reg_slave_if.slave                s_axil,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            reg_wr_pulse,
    input  logic [NUM_REGS-1:0]            hw_we,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_wdata
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFFS_W = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_WIDTH - OFFS_W;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} wstate_e;
    typedef enum logic       {R_IDLE, R_RESP}           rstate_e;

    // Write path state
    wstate_e               wstate_q, wstate_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic [IDX_W-1:0]      widx_q, widx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [NUM_REGS-1:0]   pulse_q, pulse_d;

    // Read path state
    rstate_e               rstate_q, rstate_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    // Decode helpers
    logic [31:0]           widx_ext;
    logic [31:0]           ridx_ext;
    logic                  widx_ok;
    logic                  ridx_ok;
    logic [NUM_REGS-1:0]   wsel;
    logic                  commit;
    logic                  commit_err;
    logic [NUM_REGS-1:0]   commit_hit;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  aw_hs;
    logic                  w_hs;

    // Protection bits and sub-word address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{s_axil.awprot, s_axil.arprot,
                           s_axil.awaddr[OFFS_W-1:0], s_axil.araddr[OFFS_W-1:0]};

    assign widx_ext = 32'(widx_q);
    assign ridx_ext = 32'(s_axil.araddr[ADDR_WIDTH-1:OFFS_W]);
    assign widx_ok  = widx_ext < NUM_REGS;
    assign ridx_ok  = ridx_ext < NUM_REGS;

    // wsel is one-hot for an in-range index and all-zero otherwise, so the
    // RO check below needs no separate bounds guard.
    assign commit     = (wstate_q == W_COMMIT);
    assign commit_err = !widx_ok || (|(wsel & RO_MASK));
    assign commit_hit = (commit && !commit_err) ? wsel : '0;

    // Register array: AXI commit has priority over the hardware load port.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        logic [DATA_WIDTH-1:0] word_q, word_d;

        assign wsel[gi] = (widx_ext == 32'(gi));

        always_comb begin
            word_d = word_q;
            if (commit_hit[gi]) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (wstrb_q[b]) begin
                        word_d[b*8 +: 8] = wdata_q[b*8 +: 8];
                    end
                end
            end else if (hw_we[gi]) begin
                word_d = hw_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                word_q <= RESET_VAL[gi*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                word_q <= word_d;
            end
        end

        assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = word_q;
    end

    // Read mux; an out-of-range index falls through to zero.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ridx_ext == 32'(i)) begin
                rd_word = reg_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Write FSM: AW and W latch independently; the commit cycle follows the
    // cycle in which the second of the two has been accepted.
    always_comb begin
        wstate_d  = wstate_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        widx_d    = widx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        pulse_d   = commit_hit;
        aw_hs     = 1'b0;
        w_hs      = 1'b0;
        unique case (wstate_q)
            W_IDLE: begin
                aw_hs = s_axil.awvalid && awready_q;
                w_hs  = s_axil.wvalid && wready_q;
                if (aw_hs) begin
                    widx_d    = s_axil.awaddr[ADDR_WIDTH-1:OFFS_W];
                    awready_d = 1'b0;
                end
                if (w_hs) begin
                    wdata_d  = s_axil.wdata;
                    wstrb_d  = s_axil.wstrb;
                    wready_d = 1'b0;
                end
                if ((aw_hs || !awready_q) && (w_hs || !wready_q)) begin
                    wstate_d = W_COMMIT;
                end
            end
            W_COMMIT: begin
                bvalid_d = 1'b1;
                bresp_d  = commit_err ? RESP_SLVERR : RESP_OKAY;
                wstate_d = W_RESP;
            end
            W_RESP: begin
                if (s_axil.bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    wstate_d  = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // Read FSM: data is captured from the pre-edge register value.
    always_comb begin
        rstate_d  = rstate_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        unique case (rstate_q)
            R_IDLE: begin
                if (s_axil.arvalid && arready_q) begin
                    rdata_d   = rd_word;
                    rresp_d   = ridx_ok ? RESP_OKAY : RESP_SLVERR;
                    rvalid_d  = 1'b1;
                    arready_d = 1'b0;
                    rstate_d  = R_RESP;
                end
            end
            R_RESP: begin
                if (s_axil.rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    rstate_d  = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            widx_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            pulse_q   <= '0;
            rstate_q  <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            wstate_q  <= wstate_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            widx_q    <= widx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            pulse_q   <= pulse_d;
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign s_axil.awready = awready_q;
    assign s_axil.wready  = wready_q;
    assign s_axil.bvalid  = bvalid_q;
    assign s_axil.bresp   = bresp_q;
    assign s_axil.arready = arready_q;
    assign s_axil.rvalid  = rvalid_q;
    assign s_axil.rdata   = rdata_q;
    assign s_axil.rresp   = rresp_q;
    assign reg_wr_pulse   = pulse_q;
endmodule

// File: tb/tb_axil_reg_slave.sv
// -----------------------------------------------------------------------------
// tb_axil_reg_slave
// Drives directed and randomized AXI4-Lite / hardware-port traffic into
// axil_reg_slave and checks every cycle against a transaction-level model.
// -----------------------------------------------------------------------------
module tb_axil_reg_slave;
    localparam int AW = 13;
    localparam int DW = 32;
    localparam int NR = 16;
    localparam logic [NR-1:0] RO = 16'h0004;

    function automatic logic [NR*DW-1:0] mk_rv();
        logic [NR*DW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = 32'h1000_0000 + 32'(i);
        return v;
    endfunction
    localparam logic [NR*DW-1:0] RV = mk_rv();

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [NR-1:0]    hw_we = '0;
    logic [NR*DW-1:0] hw_wdata = '0;
    logic [NR*DW-1:0] reg_q;
    logic [NR-1:0]    reg_wr_pulse;

    axil_reg_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    axil_reg_slave #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR),
        .RO_MASK(RO), .RESET_VAL(RV)
    ) dut (
        .clk(clk), .reset(reset), .s_axil(bus),
        .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse),
        .hw_we(hw_we), .hw_wdata(hw_wdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic [DW-1:0] m_regs [NR];
    logic          m_awr, m_wr, m_bvalid, m_arr, m_rvalid;
    logic [1:0]    m_bresp, m_rresp, m_wph;
    logic [DW-1:0] m_rdata, m_wd;
    logic [3:0]    m_ws;
    int            m_awidx;
    logic [NR-1:0] m_pulse;

    initial begin : model_and_compare
        logic [DW-1:0]    old [NR];
        logic [NR*DW-1:0] flat;
        int               idx;
        forever begin
            @(posedge clk);
            if (reset) begin
                for (int i = 0; i < NR; i++) m_regs[i] = RV[i*DW +: DW];
                m_awr = 1; m_wr = 1; m_arr = 1; m_bvalid = 0; m_rvalid = 0;
                m_bresp = 0; m_rresp = 0; m_rdata = 0; m_wph = 0; m_pulse = 0;
            end else begin
                old = m_regs;
                m_pulse = '0;
                // read channel: one outstanding, data is the pre-edge value
                if (m_rvalid) begin
                    if (bus.rready) begin m_rvalid = 0; m_arr = 1; end
                end else if (bus.arvalid) begin
                    idx = int'(bus.araddr >> 2);
                    m_rvalid = 1; m_arr = 0;
                    if (idx < NR) begin m_rdata = old[idx]; m_rresp = 2'b00; end
                    else begin m_rdata = 0; m_rresp = 2'b10; end
                end
                // hardware loads, later overridden by a same-edge AXI commit
                for (int i = 0; i < NR; i++)
                    if (hw_we[i]) m_regs[i] = hw_wdata[i*DW +: DW];
                // write transaction phases: collect, commit, respond
                case (m_wph)
                    2'd0: begin
                        if (bus.awvalid && m_awr) begin m_awidx = int'(bus.awaddr >> 2); m_awr = 0; end
                        if (bus.wvalid && m_wr) begin m_wd = bus.wdata; m_ws = bus.wstrb; m_wr = 0; end
                        if (!m_awr && !m_wr) m_wph = 2'd1;
                    end
                    2'd1: begin
                        if (m_awidx < NR && !RO[m_awidx]) begin
                            for (int b = 0; b < 4; b++)
                                m_regs[m_awidx][b*8 +: 8] = m_ws[b] ? m_wd[b*8 +: 8] : old[m_awidx][b*8 +: 8];
                            m_pulse[m_awidx] = 1'b1;
                            m_bresp = 2'b00;
                        end else begin
                            m_bresp = 2'b10;
                        end
                        m_bvalid = 1; m_wph = 2'd2;
                    end
                    default: begin
                        if (bus.bready) begin m_bvalid = 0; m_awr = 1; m_wr = 1; m_wph = 2'd0; end
                    end
                endcase
            end
            @(negedge clk);
            chk("awready", bus.awready, m_awr);
            chk("wready", bus.wready, m_wr);
            chk("bvalid", bus.bvalid, m_bvalid);
            if (m_bvalid) chk("bresp", bus.bresp, m_bresp);
            chk("arready", bus.arready, m_arr);
            chk("rvalid", bus.rvalid, m_rvalid);
            if (m_rvalid) begin
                chk("rdata", bus.rdata, m_rdata);
                chk("rresp", bus.rresp, m_rresp);
            end
            chk("reg_wr_pulse", reg_wr_pulse, m_pulse);
            for (int i = 0; i < NR; i++) flat[i*DW +: DW] = m_regs[i];
            total++;
            if (reg_q !== flat) begin
                bad++;
                $display("FAIL reg_q: got %h expected %h", reg_q, flat);
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [3:0] s, input int w_lead);
        int n;
        bit aw_done, w_done;
        n = 0; aw_done = 0; w_done = 0;
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
        bus.wvalid = 1; bus.awvalid = (w_lead == 0);
        while (!(aw_done && w_done) && n < 50) begin
            if (bus.awvalid && bus.awready) aw_done = 1;
            if (bus.wvalid && bus.wready) w_done = 1;
            tick(); n++;
            if (aw_done) bus.awvalid = 0;
            if (w_done) bus.wvalid = 0;
            if (n >= w_lead && !aw_done) bus.awvalid = 1;
        end
        chk("write_accept", {aw_done, w_done}, 2'b11);
        $display("write addr=%h data=%h strb=%h accepted", a, d, s);
        bus.awvalid = 0; bus.wvalid = 0;
    endtask

    task automatic wait_b(input int hold, output logic [1:0] resp);
        int n;
        n = 0;
        bus.bready = 0;
        while (!bus.bvalid && n < 20) begin tick(); n++; end
        chk("bvalid_wait", bus.bvalid, 1'b1);
        resp = bus.bresp;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("bvalid_hold", bus.bvalid, 1'b1);
            chk("bresp_hold", bus.bresp, resp);
            chk("awready_hold", bus.awready, 1'b0);
            chk("wready_hold", bus.wready, 1'b0);
        end
        bus.bready = 1; tick(); bus.bready = 0;
        $display("bresp=%b", resp);
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic [1:0] r);
        int n;
        bit done;
        n = 0; done = 0;
        bus.araddr = a; bus.arvalid = 1;
        while (!done && n < 20) begin
            done = bus.arready;
            tick(); n++;
        end
        bus.arvalid = 0;
        n = 0;
        while (!bus.rvalid && n < 20) begin tick(); n++; end
        chk("rvalid_wait", bus.rvalid, 1'b1);
        d = bus.rdata; r = bus.rresp;
        bus.rready = 1; tick(); bus.rready = 0;
        $display("read addr=%h data=%h rresp=%b", a, d, r);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-3:0] i;
        i = (AW-2)'($urandom_range(0, 17));
        return {i, 2'($urandom_range(0, 3))};
    endfunction

    // ---------------- stimulus ----------------
    initial begin : stim
        logic [1:0]    r;
        logic [DW-1:0] d;
        logic          aw_f, w_f, ar_f;
        bit            drain;
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
        bus.bready = 0; bus.rready = 0;
        bus.awaddr = '0; bus.araddr = '0; bus.wdata = '0; bus.wstrb = '0;
        bus.awprot = '0; bus.arprot = '0;
        repeat (3) tick();
        reset = 0;
        chk("rst_awready", bus.awready, 1'b1);
        chk("rst_arready", bus.arready, 1'b1);
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_reg1", reg_q[63:32], 32'h1000_0001);

        // full write, latency and pulse
        axi_write(13'h004, 32'hDEADBEEF, 4'hF, 0);
        chk("t1_bvalid_early", bus.bvalid, 1'b0);
        tick();
        chk("t1_bvalid", bus.bvalid, 1'b1);
        chk("t1_reg1", reg_q[63:32], 32'hDEADBEEF);
        chk("t1_pulse", reg_wr_pulse, 16'h0002);
        wait_b(0, r);
        chk("t1_bresp", r, 2'b00);
        chk("t1_pulse_gone", reg_wr_pulse, 16'h0000);
        axi_read(13'h004, d, r);
        chk("t1_rdata", d, 32'hDEADBEEF);
        chk("t1_rresp", r, 2'b00);

        // W first, byte strobe, backpressured response
        axi_write(13'h004, 32'h00AB0000, 4'b0100, 3);
        wait_b(5, r);
        chk("t2_bresp", r, 2'b00);
        chk("t2_reg1", reg_q[63:32], 32'hDEABBEEF);

        // out-of-range and read-only
        axi_write(13'h040, 32'h12345678, 4'hF, 0);
        wait_b(0, r);
        chk("t3_oor_bresp", r, 2'b10);
        axi_read(13'h040, d, r);
        chk("t3_oor_rdata", d, 32'h0);
        chk("t3_oor_rresp", r, 2'b10);
        axi_write(13'h008, 32'hFFFFFFFF, 4'hF, 0);
        wait_b(0, r);
        chk("t3_ro_bresp", r, 2'b10);
        chk("t3_ro_reg2", reg_q[95:64], 32'h1000_0002);
        axi_read(13'h008, d, r);
        chk("t3_ro_rresp", r, 2'b00);
        chk("t3_ro_rdata", d, 32'h1000_0002);

        // read coinciding with commit sees the old value
        axi_write(13'h00C, 32'h1, 4'hF, 0);
        wait_b(0, r);
        axi_write(13'h00C, 32'h2, 4'hF, 0);
        bus.araddr = 13'h00C; bus.arvalid = 1;
        tick();
        bus.arvalid = 0;
        chk("t4_rvalid", bus.rvalid, 1'b1);
        chk("t4_rdata_old", bus.rdata, 32'h1);
        bus.rready = 1; tick(); bus.rready = 0;
        wait_b(0, r);
        axi_read(13'h00C, d, r);
        chk("t4_rdata_new", d, 32'h2);

        // AXI commit beats hardware load in the same cycle
        axi_write(13'h00C, 32'h77, 4'hF, 0);
        hw_we = 16'h0008; hw_wdata[3*DW +: DW] = 32'h55;
        tick();
        hw_we = '0;
        chk("t5_axi_wins", reg_q[127:96], 32'h77);
        wait_b(0, r);
        hw_we = 16'h0008;
        tick();
        hw_we = '0;
        chk("t5_hw_alone", reg_q[127:96], 32'h55);

        // reset with both responses pending
        axi_write(13'h004, 32'h1234, 4'hF, 0);
        tick();
        bus.araddr = 13'h000; bus.arvalid = 1;
        tick();
        bus.arvalid = 0;
        chk("t6_bvalid_pre", bus.bvalid, 1'b1);
        chk("t6_rvalid_pre", bus.rvalid, 1'b1);
        reset = 1;
        tick();
        chk("t6_bvalid", bus.bvalid, 1'b0);
        chk("t6_rvalid", bus.rvalid, 1'b0);
        chk("t6_awready", bus.awready, 1'b1);
        chk("t6_wready", bus.wready, 1'b1);
        chk("t6_arready", bus.arready, 1'b1);
        chk("t6_reg_q", (reg_q === RV) ? 1'b1 : 1'b0, 1'b1);
        reset = 0;
        tick();

        // randomized traffic, followed by a drain
        for (int c = 0; c < 700; c++) begin
            drain = (c >= 640);
            aw_f = bus.awvalid && bus.awready;
            w_f  = bus.wvalid && bus.wready;
            ar_f = bus.arvalid && bus.arready;
            tick();
            if (aw_f) begin bus.awvalid = 0; $display("rand aw addr=%h", bus.awaddr); end
            if (w_f)  begin bus.wvalid = 0;  $display("rand w data=%h strb=%h", bus.wdata, bus.wstrb); end
            if (ar_f) begin bus.arvalid = 0; $display("rand ar addr=%h", bus.araddr); end
            if (!drain) begin
                if (!bus.awvalid && $urandom_range(0, 2) == 0) begin
                    bus.awvalid = 1; bus.awaddr = rand_addr();
                end
                if (!bus.wvalid && $urandom_range(0, 2) == 0) begin
                    bus.wvalid = 1; bus.wdata = $urandom; bus.wstrb = 4'($urandom_range(0, 15));
                end
                if (!bus.arvalid && $urandom_range(0, 2) == 0) begin
                    bus.arvalid = 1; bus.araddr = rand_addr();
                end
                bus.bready = 1'($urandom_range(0, 1));
                bus.rready = 1'($urandom_range(0, 1));
                hw_we = ($urandom_range(0, 3) == 0) ? NR'($urandom) : '0;
                for (int i = 0; i < NR; i++) hw_wdata[i*DW +: DW] = $urandom;
            end else begin
                bus.bready = 1; bus.rready = 1; hw_we = '0;
            end
        end
        chk("drain_idle", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bvalid, bus.rvalid}, 5'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
